// File: rtl/subtractor_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : subtractor_controller_if
//  Description : Signal bundle between the pushbutton subtractor controller
//                and the rest of the system (button, reload request,
//                datapath value in; load/decrement/underflow strobes and
//                status out).
//                  btn_sub    raw pushbutton, asynchronous, may bounce
//                  load_req   synchronous reload request (level)
//                  count_in   current datapath value (data_out)
//                  load_en    one-cycle strobe: datapath loads data_in
//                  sub_en     one-cycle strobe: datapath decrements by 1
//                  underflow  one-cycle strobe: press rejected at zero
//                  at_zero    registered (count_in == 0)
//                  busy       controller is not idle
//                The master modport is the environment side, the slave
//                modport is the controller side.
//  Revision    : 1.0  initial release
// ============================================================================
interface subtractor_controller_if #(
    parameter int N = 6
);
    logic         btn_sub;
    logic         load_req;
    logic [N-1:0] count_in;
    logic         load_en;
    logic         sub_en;
    logic         underflow;
    logic         at_zero;
    logic         busy;

    modport master (
        output btn_sub,
        output load_req,
        output count_in,
        input  load_en,
        input  sub_en,
        input  underflow,
        input  at_zero,
        input  busy
    );

    modport slave (
        input  btn_sub,
        input  load_req,
        input  count_in,
        output load_en,
        output sub_en,
        output underflow,
        output at_zero,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/subtractor_controller.sv
`default_nettype none
// ============================================================================
//  Module      : subtractor_controller
//  Description : Control FSM for a decrementing datapath driven by a
//                bouncing pushbutton. The button is synchronized with two
//                flops and debounced; every accepted press yields exactly one
//                decrement strobe (or an underflow strobe when the datapath
//                already reads zero), no matter how long it is held. A reload
//                is issued automatically after reset and on load_req.
//  Ports       : clk            rising-edge clock
//                rst            asynchronous reset, active low
//                bus (slave)    btn_sub, load_req, count_in in;
//                               load_en, sub_en, underflow, at_zero, busy out
//  Parameters  : N               datapath width
//                DEBOUNCE_CYCLES stable synchronized samples needed to accept
//                                a press or a release (1..255)
//  Revision    : 1.0  initial release
// ============================================================================
module subtractor_controller #(
    parameter int N               = 6,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    subtractor_controller_if.slave bus
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] INIT         = 3'd0;
    localparam logic [2:0] IDLE         = 3'd1;
    localparam logic [2:0] LOAD         = 3'd2;
    localparam logic [2:0] DEBOUNCE     = 3'd3;
    localparam logic [2:0] FIRE         = 3'd4;
    localparam logic [2:0] WAIT_RELEASE = 3'd5;

    localparam logic [7:0]   c_db_limit = 8'(DEBOUNCE_CYCLES);
    localparam logic [N-1:0] c_zero     = '0;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic       r_sync_meta;   // first synchronizer stage (may go metastable)
    logic       r_btn_s;       // synchronized button, the only button view used

    logic [2:0] r_state;
    logic [2:0] w_state_next;

    logic [7:0] r_cnt;         // debounce counter, shared by press and release
    logic [7:0] w_cnt_next;
    logic [7:0] w_cnt_inc;
    logic       w_cnt_done;    // this sample completes the stable run

    logic       w_count_zero;

    logic       r_load_en;
    logic       r_sub_en;
    logic       r_underflow;
    logic       r_at_zero;
    logic       r_busy;

    // ------------------------------------------------------------------------
    // Button synchronizer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync_meta <= 1'b0;
            r_btn_s     <= 1'b0;
        end else begin
            r_sync_meta <= bus.btn_sub;
            r_btn_s     <= r_sync_meta;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------------
    // The counter never exceeds DEBOUNCE_CYCLES-1 while counting, so the
    // 8-bit increment cannot wrap for any legal parameter value.
    assign w_cnt_inc    = r_cnt + 8'd1;
    assign w_cnt_done   = (w_cnt_inc == c_db_limit);
    assign w_count_zero = (bus.count_in == c_zero);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;

        case (r_state)
            INIT: begin
                // Power-on reload as soon as reset is released.
                w_state_next = LOAD;
                w_cnt_next   = 8'd0;
            end

            LOAD: begin
                // A button still held across a load must be released before
                // it can count as a new press.
                w_cnt_next   = 8'd0;
                w_state_next = r_btn_s ? WAIT_RELEASE : IDLE;
            end

            IDLE: begin
                w_cnt_next = 8'd0;
                if (bus.load_req) begin
                    w_state_next = LOAD;
                end else if (r_btn_s) begin
                    w_state_next = DEBOUNCE;
                end
            end

            DEBOUNCE: begin
                if (bus.load_req) begin
                    // Reload wins and the pending press is dropped.
                    w_state_next = LOAD;
                    w_cnt_next   = 8'd0;
                end else if (!r_btn_s) begin
                    // Bounce: the press was too short.
                    w_state_next = IDLE;
                    w_cnt_next   = 8'd0;
                end else if (w_cnt_done) begin
                    w_state_next = FIRE;
                    w_cnt_next   = 8'd0;
                end else begin
                    w_cnt_next   = w_cnt_inc;
                end
            end

            FIRE: begin
                w_state_next = WAIT_RELEASE;
                w_cnt_next   = 8'd0;
            end

            WAIT_RELEASE: begin
                if (bus.load_req) begin
                    w_state_next = LOAD;
                    w_cnt_next   = 8'd0;
                end else if (r_btn_s) begin
                    // Any high sample restarts the release run.
                    w_cnt_next   = 8'd0;
                end else if (w_cnt_done) begin
                    w_state_next = IDLE;
                    w_cnt_next   = 8'd0;
                end else begin
                    w_cnt_next   = w_cnt_inc;
                end
            end

            default: begin
                w_state_next = INIT;
                w_cnt_next   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= INIT;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // ------------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------------
    // Strobes are decoded from the current state and registered, so each one
    // appears on the cycle after its state and is glitch-free. LOAD and FIRE
    // are distinct states, and FIRE splits on count_in, so the three strobes
    // can never overlap. The zero test is taken while in FIRE so the decision
    // reflects the datapath value at the moment of the decrement.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_load_en   <= 1'b0;
            r_sub_en    <= 1'b0;
            r_underflow <= 1'b0;
            r_at_zero   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_load_en   <= (r_state == LOAD);
            r_sub_en    <= (r_state == FIRE) && !w_count_zero;
            r_underflow <= (r_state == FIRE) &&  w_count_zero;
            r_at_zero   <= w_count_zero;
            // Built from the next state so busy tracks the state register.
            r_busy      <= (w_state_next != IDLE);
        end
    end

    assign bus.load_en   = r_load_en;
    assign bus.sub_en    = r_sub_en;
    assign bus.underflow = r_underflow;
    assign bus.at_zero   = r_at_zero;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_subtractor_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_subtractor_controller
//  Description : Directed self-checking bench for subtractor_controller.
//                A behavioural model predicts every output each cycle; a
//                handful of literal expectations pin latency and pulse counts.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_subtractor_controller;

    localparam int DB = 4;
    localparam int W  = 6;

    logic clk;
    logic rst;

    subtractor_controller_if #(.N(W)) bus ();

    subtractor_controller #(
        .N               (W),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int n_load = 0;
    int n_sub  = 0;
    int n_unf  = 0;

    task automatic check_bit(input string name, input logic act, input logic want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s: got %b expected %b", name, act, want);
    endtask

    task automatic check_int(input string name, input int act, input int want);
        total++;
        if (act == want) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, want);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model: press accepted after DB consecutive high synchronized
    // samples following the one that left idle; release accepted after DB
    // consecutive low samples; strobes appear one cycle after the decision.
    // ------------------------------------------------------------------------
    bit   m_s1, m_s2, m_boot, m_idle, m_press, m_hold, m_load, m_fire;
    int   m_hi, m_lo;
    logic exp_load, exp_sub, exp_unf, exp_zero, exp_busy;

    always @(posedge clk or negedge rst) begin : model
        bit bs, lr, zero, nl, nf, idle, press, hold, boot;
        int hi, lo;
        if (!rst) begin
            m_s1 <= 0; m_s2 <= 0; m_boot <= 1; m_idle <= 0; m_press <= 0;
            m_hold <= 0; m_load <= 0; m_fire <= 0; m_hi <= 0; m_lo <= 0;
            exp_load <= 0; exp_sub <= 0; exp_unf <= 0; exp_zero <= 0; exp_busy <= 0;
        end else begin
            bs   = m_s2;
            lr   = bus.load_req;
            zero = (bus.count_in == '0);
            idle = m_idle; press = m_press; hold = m_hold; boot = m_boot;
            hi = m_hi; lo = m_lo; nl = 0; nf = 0;

            if (boot) begin
                boot = 0; nl = 1;
            end else if (m_load) begin
                hold = bs; idle = !bs; lo = 0;
            end else if (m_fire) begin
                hold = 1; lo = 0;
            end else if (lr && (idle || press || hold)) begin
                nl = 1; idle = 0; press = 0; hold = 0;
            end else if (idle) begin
                if (bs) begin idle = 0; press = 1; hi = 0; end
            end else if (press) begin
                if (!bs) begin
                    press = 0; idle = 1;
                end else begin
                    hi++;
                    if (hi == DB) begin press = 0; nf = 1; end
                end
            end else if (hold) begin
                if (bs) lo = 0;
                else begin
                    lo++;
                    if (lo == DB) begin hold = 0; idle = 1; end
                end
            end

            exp_load <= m_load;
            exp_sub  <= m_fire && !zero;
            exp_unf  <= m_fire && zero;
            exp_zero <= zero;
            exp_busy <= !idle;

            m_s2 <= m_s1; m_s1 <= bus.btn_sub;
            m_boot <= boot; m_idle <= idle; m_press <= press; m_hold <= hold;
            m_hi <= hi; m_lo <= lo; m_load <= nl; m_fire <= nf;
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        check_bit("model_load_en",   bus.load_en,   exp_load);
        check_bit("model_sub_en",    bus.sub_en,    exp_sub);
        check_bit("model_underflow", bus.underflow, exp_unf);
        check_bit("model_at_zero",   bus.at_zero,   exp_zero);
        check_bit("model_busy",      bus.busy,      exp_busy);
        if (bus.load_en)   n_load <= n_load + 1;
        if (bus.sub_en)    n_sub  <= n_sub + 1;
        if (bus.underflow) n_unf  <= n_unf + 1;
    end

    // Hold the button for `hold` cycles; the strobe pair {sub_en,underflow}
    // must show `want` exactly DB+3 edges after the first sampling edge.
    task automatic press(input int hold, input logic want_sub, input logic want_unf,
                         input string tag);
        bus.btn_sub = 1'b1;
        for (int k = 1; k <= hold; k++) begin
            step();
            if (k == DB + 4) begin
                check_bit({tag, "_lat_sub"}, bus.sub_en,    want_sub);
                check_bit({tag, "_lat_unf"}, bus.underflow, want_unf);
            end
        end
        bus.btn_sub = 1'b0;
    endtask

    int b_load, b_sub, b_unf;

    task automatic mark();
        b_load = n_load; b_sub = n_sub; b_unf = n_unf;
    endtask

    task automatic deltas(input string tag, input int dl, input int ds, input int du);
        check_int({tag, "_loads"},      n_load - b_load, dl);
        check_int({tag, "_subs"},       n_sub  - b_sub,  ds);
        check_int({tag, "_underflows"}, n_unf  - b_unf,  du);
    endtask

    initial begin
        rst          = 1'b0;
        bus.btn_sub  = 1'b0;
        bus.load_req = 1'b0;
        bus.count_in = 6'd25;
        step(2);

        // Reset state
        check_bit("rst_load_en",   bus.load_en,   1'b0);
        check_bit("rst_sub_en",    bus.sub_en,    1'b0);
        check_bit("rst_underflow", bus.underflow, 1'b0);
        check_bit("rst_at_zero",   bus.at_zero,   1'b0);
        check_bit("rst_busy",      bus.busy,      1'b0);

        // Power-on load: visible after the 2nd edge, then idle
        mark();
        rst = 1'b1;
        step();
        check_bit("por_e1_load_en", bus.load_en, 1'b0);
        check_bit("por_e1_busy",    bus.busy,    1'b1);
        step();
        check_bit("por_e2_load_en", bus.load_en, 1'b1);
        check_bit("por_e2_busy",    bus.busy,    1'b0);
        step();
        check_bit("por_e3_load_en", bus.load_en, 1'b0);
        step(4);
        deltas("por", 1, 0, 0);

        // Three clean presses at count 25
        mark();
        for (int i = 0; i < 3; i++) begin
            press(10, 1'b1, 1'b0, "clean");
            step(10);
        end
        deltas("clean", 0, 3, 0);

        // Bouncing button: 2-cycle high/low runs never survive debounce
        mark();
        for (int i = 0; i < 5; i++) begin
            bus.btn_sub = 1'b1; step(2);
            bus.btn_sub = 1'b0; step(2);
        end
        step(10);
        deltas("bounce", 0, 0, 0);
        check_bit("bounce_idle_busy", bus.busy, 1'b0);

        // Press at zero saturates
        mark();
        bus.count_in = 6'd0;
        step();
        press(10, 1'b0, 1'b1, "zero");
        check_bit("zero_at_zero", bus.at_zero, 1'b1);
        step(10);
        deltas("zero", 0, 0, 1);
        bus.count_in = 6'd25;
        step();

        // Long hold, short release gap rejected, DB-long gap accepted
        mark();
        press(100, 1'b1, 1'b0, "hold");
        step(DB - 1);
        bus.btn_sub = 1'b1; step(10);
        bus.btn_sub = 1'b0; step(DB);
        press(10, 1'b1, 1'b0, "regap");
        step(10);
        deltas("hold", 0, 2, 0);

        // load_req in the cycle the synchronized button first reads high
        mark();
        bus.btn_sub = 1'b1;
        step(2);
        bus.load_req = 1'b1;
        step();
        bus.load_req = 1'b0;
        step(9);
        bus.btn_sub = 1'b0;
        step(10);
        deltas("ldrise", 1, 0, 0);

        // load_req during debounce aborts the press
        mark();
        bus.btn_sub = 1'b1;
        step(4);
        bus.load_req = 1'b1;
        step();
        bus.load_req = 1'b0;
        step(9);
        bus.btn_sub = 1'b0;
        step(10);
        deltas("lddeb", 1, 0, 0);

        // Reset mid-debounce discards the press; only the power-on load follows
        mark();
        bus.btn_sub = 1'b1;
        step(5);
        rst = 1'b0;
        step(2);
        bus.btn_sub = 1'b0;
        rst = 1'b1;
        step(15);
        deltas("midrst", 1, 0, 0);

        step(2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/subtractor_controller.md
SUBTRACTOR_CONTROLLER -- requirements
Module: subtractor_controller

Interface
REQ-001 Parameter N, default 6: width of the datapath value.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4, legal range 1..255: number of consecutive stable synchronized samples required to accept a press or a release.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 btn_sub  input  1  raw pushbutton, active-high, asynchronous to clk, may bounce.
REQ-006 load_req  input  1  synchronous level request to reload the datapath from its data input.
REQ-007 count_in  input  N  current value from the subtractor datapath's data_out.
REQ-008 load_en  output  1  one-cycle strobe; the datapath loads data_in.
REQ-009 sub_en  output  1  one-cycle strobe; the datapath decrements by exactly 1.
REQ-010 underflow  output  1  one-cycle strobe; an accepted press was rejected because count_in was 0.
REQ-011 at_zero  output  1  registered copy of (count_in == 0).
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 btn_sub SHALL pass through a 2-flop synchronizer (btn_s) before any use; no logic SHALL sample btn_sub directly.
REQ-014 FSM states SHALL be INIT, IDLE, LOAD, DEBOUNCE, FIRE, WAIT_RELEASE.
REQ-015 INIT: entered from reset; SHALL go to LOAD on the first edge after rst deasserts (automatic power-on load).
REQ-016 LOAD: load_en=1 for exactly this one cycle; next state WAIT_RELEASE if btn_s=1, else IDLE.
REQ-017 IDLE: load_req=1 -> LOAD; else btn_s=1 -> DEBOUNCE with debounce counter cleared; else stay.
REQ-018 load_req SHALL have priority over btn_s in IDLE, DEBOUNCE and WAIT_RELEASE; from DEBOUNCE it aborts the press (no sub_en).
REQ-019 DEBOUNCE: counter increments on each cycle with btn_s=1; btn_s=0 -> IDLE with no strobe; counter reaching DEBOUNCE_CYCLES -> FIRE.
REQ-020 FIRE: lasts exactly one cycle; count_in != 0 -> sub_en=1; count_in == 0 -> underflow=1 and sub_en=0 (saturate; never wrap to 2^N-1); next state WAIT_RELEASE.
REQ-021 WAIT_RELEASE: counter counts consecutive btn_s=0 cycles and resets on btn_s=1; reaching DEBOUNCE_CYCLES -> IDLE.
REQ-022 A held button SHALL produce exactly one sub_en or underflow strobe, regardless of hold length.
REQ-023 Bounces shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no strobe.
REQ-024 Press latency: given a clean press, sub_en SHALL rise exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples btn_sub=1.
REQ-025 load_en, sub_en and underflow SHALL be mutually exclusive and registered (glitch-free).
REQ-026 at_zero SHALL update every cycle, one cycle behind count_in.

Reset
REQ-027 rst=0 SHALL immediately force: state INIT, synchronizer flops 0, debounce counter 0, and load_en, sub_en, underflow, at_zero, busy all 0.
REQ-028 rst asserted mid-debounce or mid-hold SHALL discard the pending press; after release the only strobe is the INIT load_en.

Verification
REQ-029 Release rst and hold other inputs at 0 -> a single load_en pulse on the 2nd edge after release, then IDLE with busy=0.
REQ-030 count_in=25 with 3 clean presses of 10 cycles each, separated by 10 low cycles -> exactly 3 sub_en pulses and no underflow; each pulse at DEBOUNCE_CYCLES+3 edges after its press.
REQ-031 btn_sub toggling every 2 cycles for 20 cycles (DEBOUNCE_CYCLES=4), then low -> 0 strobes and return to IDLE.
REQ-032 count_in=0 with 1 clean press -> underflow=1 for one cycle, sub_en stays 0, at_zero=1.
REQ-033 Button held for 100 cycles -> exactly 1 sub_en; the next press is accepted only after 4 stable low samples.
REQ-034 load_req=1 in the same cycle btn_s rises, and separately during DEBOUNCE -> load_en pulse, no sub_en for that press.
